// File: rtl/step_pkg.sv
// Shared constants, state encoding and phase helpers for the stepper coil bus.
package step_pkg;

  localparam int unsigned COIL_W = 4;

  typedef logic [COIL_W-1:0] coil_t;

  localparam coil_t PH_OFF = 4'b0000;
  localparam coil_t PH_A   = 4'b0001;
  localparam coil_t PH_B   = 4'b0010;
  localparam coil_t PH_C   = 4'b0100;
  localparam coil_t PH_D   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOCKED = 2'b01,
    FAULT  = 2'b10
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_SKIP    = 2'b10;

  // True for exactly one energised coil.
  function automatic logic is_onehot(input coil_t p);
    return (p == PH_A) || (p == PH_B) || (p == PH_C) || (p == PH_D);
  endfunction

  // Next phase in the forward rotation A->B->C->D->A.
  function automatic coil_t rot_fwd(input coil_t p);
    return {p[2:0], p[3]};
  endfunction

  // Next phase in the reverse rotation.
  function automatic coil_t rot_rev(input coil_t p);
    return {p[0], p[3:1]};
  endfunction

  // Phase two steps away; reaching it in one move means a phase was skipped.
  function automatic coil_t rot_opp(input coil_t p);
    return {p[1:0], p[3:2]};
  endfunction

endpackage

// File: rtl/coil_sync_filter.sv
// Two-flop synchroniser plus a stability filter for the raw coil pattern.
module coil_sync_filter
  import step_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  coil_t coil,
  output coil_t pattern,
  output logic  change
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(FILTER_CYCLES);

  coil_t            sync1;
  coil_t            sync2;
  coil_t            cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Stability count: restart at 1 on a new candidate, otherwise climb to the target and hold.
  always_comb begin
    cnt_nxt = cnt;
    if (sync2 != cand) begin
      cnt_nxt = CNT_W'(1);
    end else if (cnt < CNT_TARGET) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Synchroniser, candidate tracking and accepted-pattern update with change strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= PH_OFF;
      sync2   <= PH_OFF;
      cand    <= PH_OFF;
      cnt     <= '0;
      pattern <= PH_OFF;
      change  <= 1'b0;
    end else begin
      sync1  <= coil;
      sync2  <= sync1;
      cand   <= sync2;
      cnt    <= cnt_nxt;
      change <= 1'b0;
      if (cnt_nxt == CNT_TARGET) begin
        pattern <= sync2;
        change  <= (sync2 != pattern);
      end
    end
  end

endmodule

// File: rtl/step_phase_decoder.sv
// Decodes filtered coil phases into step pulses, direction, position and step period.
module step_phase_decoder
  import step_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned POS_WIDTH     = 16,
  parameter int unsigned PERIOD_WIDTH  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              coil,
  input  logic                    clear,
  output logic                    step_pulse,
  output logic                    dir,
  output logic [POS_WIDTH-1:0]    position,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    active,
  output logic                    fault,
  output logic [1:0]              fault_code
);

  localparam logic [PERIOD_WIDTH-1:0] PCNT_MAX = '1;

  coil_t acc;
  logic  acc_chg;

  state_t                  state_q;
  state_t                  state_nxt;
  coil_t                   phase_q;
  coil_t                   phase_nxt;
  logic [PERIOD_WIDTH-1:0] pcnt_q;
  logic                    step_c;
  logic                    fwd_c;
  logic                    fault_set_c;
  logic [1:0]              cause_c;

  coil_sync_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .coil   (coil),
    .pattern(acc),
    .change (acc_chg)
  );

  // State register and remembered phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= PH_OFF;
    end else begin
      state_q <= state_nxt;
      phase_q <= phase_nxt;
    end
  end

  // Next state and step/fault decisions, evaluated when the accepted pattern changes.
  always_comb begin
    state_nxt   = state_q;
    phase_nxt   = phase_q;
    step_c      = 1'b0;
    fwd_c       = 1'b0;
    fault_set_c = 1'b0;
    cause_c     = FC_NONE;
    if (clear) begin
      // Clear wins: any pending step is dropped and the decoder relocks on the current pattern.
      state_nxt = is_onehot(acc) ? LOCKED : IDLE;
      phase_nxt = acc;
    end else if (acc_chg) begin
      unique case (state_q)
        IDLE: begin
          if (is_onehot(acc)) begin
            state_nxt = LOCKED;
            phase_nxt = acc;
          end else if (acc != PH_OFF) begin
            state_nxt   = FAULT;
            fault_set_c = 1'b1;
            cause_c     = FC_ILLEGAL;
          end
        end
        LOCKED: begin
          if (acc == rot_fwd(phase_q)) begin
            step_c    = 1'b1;
            fwd_c     = 1'b1;
            phase_nxt = acc;
          end else if (acc == rot_rev(phase_q)) begin
            step_c    = 1'b1;
            phase_nxt = acc;
          end else if (acc == rot_opp(phase_q)) begin
            state_nxt   = FAULT;
            fault_set_c = 1'b1;
            cause_c     = FC_SKIP;
          end else if (acc == PH_OFF) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = FAULT;
            fault_set_c = 1'b1;
            cause_c     = FC_ILLEGAL;
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Registered outputs: step pulse, direction, position, period and sticky fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      position   <= '0;
      period     <= '0;
      pcnt_q     <= '0;
      active     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      step_pulse <= step_c;
      active     <= (state_nxt == LOCKED);
      if (clear) begin
        position <= '0;
      end else if (step_c) begin
        dir      <= fwd_c;
        position <= fwd_c ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
      end
      // Counter restarts the cycle the pulse is visible, so period equals step spacing.
      if (clear) begin
        pcnt_q <= '0;
      end else if (step_pulse) begin
        pcnt_q <= PERIOD_WIDTH'(1);
      end else if (pcnt_q != PCNT_MAX) begin
        pcnt_q <= pcnt_q + PERIOD_WIDTH'(1);
      end
      if (clear) begin
        period <= '0;
      end else if (step_c) begin
        period <= (pcnt_q == PCNT_MAX) ? PCNT_MAX : pcnt_q + PERIOD_WIDTH'(1);
      end
      if (clear) begin
        fault      <= 1'b0;
        fault_code <= FC_NONE;
      end else if (fault_set_c && !fault) begin
        fault      <= 1'b1;
        fault_code <= cause_c;
      end
    end
  end

endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed bench for step_phase_decoder: stepping, glitch rejection, faults, wrap and reset.
module tb_step_phase_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  coil;
  logic        clear;

  logic        step_pulse;
  logic        dir;
  logic [15:0] position;
  logic [23:0] period;
  logic        active;
  logic        fault;
  logic [1:0]  fault_code;

  logic        s_step_pulse;
  logic        s_dir;
  logic [3:0]  s_position;
  logic [23:0] s_period;
  logic        s_active;
  logic        s_fault;
  logic [1:0]  s_fault_code;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_total = 0;
  int base;

  always #5 clk = ~clk;

  step_phase_decoder #(.FILTER_CYCLES(4), .POS_WIDTH(16), .PERIOD_WIDTH(24)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .coil      (coil),
    .clear     (clear),
    .step_pulse(step_pulse),
    .dir       (dir),
    .position  (position),
    .period    (period),
    .active    (active),
    .fault     (fault),
    .fault_code(fault_code)
  );

  step_phase_decoder #(.FILTER_CYCLES(4), .POS_WIDTH(4), .PERIOD_WIDTH(24)) u_small (
    .clk       (clk),
    .rst       (rst),
    .coil      (coil),
    .clear     (clear),
    .step_pulse(s_step_pulse),
    .dir       (s_dir),
    .position  (s_position),
    .period    (s_period),
    .active    (s_active),
    .fault     (s_fault),
    .fault_code(s_fault_code)
  );

  // Count cycles with step_pulse high on the main instance.
  always @(negedge clk) begin
    if (step_pulse) pulse_total <= pulse_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    coil = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    logic [3:0] p;
    rst   = 1'b0;
    coil  = 4'b0000;
    clear = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_step",  32'(step_pulse), 32'h0);
    check("rst_dir",   32'(dir),        32'h0);
    check("rst_pos",   32'(position),   32'h0);
    check("rst_period", 32'(period),    32'h0);
    check("rst_active", 32'(active),    32'h0);
    check("rst_fault", 32'(fault),      32'h0);
    check("rst_code",  32'(fault_code), 32'h0);

    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_active", 32'(active), 32'h0);

    // Lock on 0001 without counting, then four forward steps 20 cycles apart
    base = pulse_total;
    hold(4'b0001, 20);
    check("lock_active", 32'(active), 32'h1);
    check("lock_nostep", 32'(pulse_total - base), 32'h0);
    hold(4'b0010, 20);
    hold(4'b0100, 20);
    hold(4'b1000, 20);
    hold(4'b0001, 20);
    check("fwd_pulses", 32'(pulse_total - base), 32'd4);
    check("fwd_dir",    32'(dir),      32'h1);
    check("fwd_pos",    32'(position), 32'd4);
    check("fwd_active", 32'(active),   32'h1);
    check("fwd_period", 32'(period),   32'd20);

    // Clear while locked, then two reverse steps and de-energise
    pulse_clear();
    check("clr_pos",    32'(position), 32'h0);
    check("clr_period", 32'(period),   32'h0);
    check("clr_active", 32'(active),   32'h1);
    base = pulse_total;
    hold(4'b1000, 20);
    hold(4'b0100, 20);
    check("rev_pulses", 32'(pulse_total - base), 32'd2);
    check("rev_dir",    32'(dir),      32'h0);
    check("rev_pos",    32'(position), 32'hFFFE);
    hold(4'b0000, 20);
    check("off_active", 32'(active),   32'h0);
    check("off_pos",    32'(position), 32'hFFFE);
    check("off_dir",    32'(dir),      32'h0);

    // Relock on 0001, a 3-cycle glitch is rejected, a 4-cycle pattern is accepted
    hold(4'b0001, 20);
    base = pulse_total;
    hold(4'b0010, 3);
    hold(4'b0001, 20);
    check("glitch_pulses", 32'(pulse_total - base), 32'h0);
    check("glitch_pos",    32'(position), 32'hFFFE);
    hold(4'b0010, 4);
    hold(4'b0010, 16);
    check("accept_pulses", 32'(pulse_total - base), 32'd1);
    check("accept_pos",    32'(position), 32'hFFFF);
    check("accept_dir",    32'(dir),      32'h1);

    // Illegal pattern: fault with code 01 that later activity does not overwrite
    hold(4'b0011, 20);
    check("ill_fault",  32'(fault),      32'h1);
    check("ill_code",   32'(fault_code), 32'h1);
    check("ill_active", 32'(active),     32'h0);
    hold(4'b0001, 20);
    hold(4'b0100, 20);
    check("ill_hold_code", 32'(fault_code), 32'h1);
    check("ill_hold_pos",  32'(position),   32'hFFFF);
    pulse_clear();
    check("ill_clr_fault",  32'(fault),      32'h0);
    check("ill_clr_code",   32'(fault_code), 32'h0);
    check("ill_clr_pos",    32'(position),   32'h0);
    check("ill_clr_active", 32'(active),     32'h1);

    // Skipped phase: 0001 jumps straight to 0100
    hold(4'b1000, 20);
    hold(4'b0001, 20);
    check("pre_skip_pos", 32'(position), 32'd2);
    base = pulse_total;
    hold(4'b0100, 20);
    check("skip_fault",  32'(fault),      32'h1);
    check("skip_code",   32'(fault_code), 32'h2);
    check("skip_pulses", 32'(pulse_total - base), 32'h0);
    check("skip_pos",    32'(position),   32'd2);
    check("skip_active", 32'(active),     32'h0);
    pulse_clear();
    check("skip_clr_fault",  32'(fault),  32'h0);
    check("skip_clr_active", 32'(active), 32'h1);

    // Eight forward steps: the 4-bit instance wraps to -8
    p = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      p = {p[2:0], p[3]};
      hold(p, 12);
    end
    check("wrap_pos16",  32'(position),   32'd8);
    check("wrap_pos4",   32'(s_position), 32'h8);
    check("wrap_period", 32'(period),     32'd12);
    check("wrap_dir",    32'(dir),        32'h1);

    // Asynchronous reset between clock edges clears everything at once
    hold(4'b1000, 5);
    #3;
    rst = 1'b0;
    #1;
    check("arst_step",   32'(step_pulse), 32'h0);
    check("arst_dir",    32'(dir),        32'h0);
    check("arst_pos",    32'(position),   32'h0);
    check("arst_period", 32'(period),     32'h0);
    check("arst_active", 32'(active),     32'h0);
    check("arst_fault",  32'(fault),      32'h0);
    check("arst_code",   32'(fault_code), 32'h0);
    check("arst_pos4",   32'(s_position), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
